// File: rtl/quadrature_decoder.sv
// Quadrature (Gray-coded A/B) decoder: synchronizes both phases, decodes
// legal up/down steps into a wrap-around position count with a step pulse
// and direction, and raises a sticky flag on illegal (two-bit) transitions.
// A short INIT phase after reset lets the synchronizers flush without
// producing spurious steps or errors.
module quadrature_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] a_sync_p0;
  logic [SYNC_STAGES-1:0] b_sync_p0;
  logic [1:0]             s_p1;
  logic [1:0]             prev_p1;
  logic [1:0]             diff;
  logic [2:0]             init_cnt;
  logic                   init_done;
  logic                   up;
  logic                   down;
  logic                   illegal;

  // Position of a Gray-coded {a,b} pair along the up sequence 00,10,11,01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Stage 0: per-phase synchronizer chains, new sample shifts in at bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync_p0 <= '0;
      b_sync_p0 <= '0;
    end else begin
      a_sync_p0 <= {a_sync_p0[SYNC_STAGES-2:0], a_in};
      b_sync_p0 <= {b_sync_p0[SYNC_STAGES-2:0], b_in};
    end
  end

  assign s_p1      = {a_sync_p0[SYNC_STAGES-1], b_sync_p0[SYNC_STAGES-1]};
  assign init_done = (init_cnt == INIT_LAST);

  // Stage 1: previous decoded state, tracked in both INIT and RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_p1 <= 2'b00;
    else      prev_p1 <= s_p1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= INIT;
    else      state_q <= state_d;
  end

  // INIT length counter; holds once the flush period has elapsed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               init_cnt <= '0;
    else if (state_q == INIT && !init_done) init_cnt <= init_cnt + 3'd1;
  end

  // Next state and transition decode; decode is suppressed during INIT.
  always_comb begin
    state_d = state_q;
    up      = 1'b0;
    down    = 1'b0;
    illegal = 1'b0;
    diff    = gray_pos(s_p1) - gray_pos(prev_p1);
    case (state_q)
      INIT: begin
        if (init_done) state_d = RUN;
      end
      default: begin
        up      = (diff == 2'd1);
        down    = (diff == 2'd3);
        illegal = (diff == 2'd2);
      end
    endcase
  end

  // Stage 2: registered outputs; clr overrides count and error updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dir  <= 1'b0;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      step <= up | down;
      if (up)        dir <= 1'b1;
      else if (down) dir <= 1'b0;
      if (clr)       cnt <= '0;
      else if (up)   cnt <= cnt + ONE;
      else if (down) cnt <= cnt - ONE;
      if (clr)          err <= 1'b0;
      else if (illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cnt;
  logic       dir;
  logic       step;
  logic       err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base_pulses;

  logic [3:0] m_cnt;
  logic       m_err;

  // Up sequence 00,10,11,01 as separate a/b tables.
  logic seq_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic seq_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  quadrature_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_in (a_in),
    .b_in (b_in),
    .clr  (clr),
    .cnt  (cnt),
    .dir  (dir),
    .step (step),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) pulses++;
  endtask

  // Apply one input change, then verify the 2-cycle latency and the result.
  task automatic apply(input logic na, input logic nb, input logic clr_at_decode,
                       input logic [3:0] exp_cnt, input logic exp_step,
                       input logic exp_dir, input logic exp_err, input string tag);
    a_in = na;
    b_in = nb;
    tick();
    tick();
    check({tag, "_hold_cnt"}, 32'(cnt), 32'(m_cnt));
    check({tag, "_hold_step"}, 32'(step), 32'd0);
    check({tag, "_hold_err"}, 32'(err), 32'(m_err));
    if (clr_at_decode) clr = 1'b1;
    tick();
    clr = 1'b0;
    check({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    check({tag, "_step"}, 32'(step), 32'(exp_step));
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, "_step_end"}, 32'(step), 32'd0);
    m_cnt = exp_cnt;
    m_err = exp_err;
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    m_cnt = 4'd0;
    m_err = 1'b0;
  endtask

  initial begin
    // Reset held with both phases high.
    #2;
    rst  = 1'b0;
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Release: INIT for three edges, no spurious activity.
    rst    = 1'b1;
    pulses = 0;
    tick();
    tick();
    check("init_state_e2", 32'(int'(dut.state_q)), 32'd0);
    tick();
    check("run_state_e3", 32'(int'(dut.state_q)), 32'd1);
    tick();
    tick();
    tick();
    check("init_no_step", 32'(pulses), 32'd0);
    check("init_err", 32'(err), 32'd0);
    check("init_cnt", 32'(cnt), 32'd0);
    m_cnt = 4'd0;
    m_err = 1'b0;

    // Walk 11 -> 01 -> 00 (both up), then clear.
    apply(1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, "pre_up1");
    apply(1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, "pre_up2");
    pulse_clr("clr0");

    // Four full up cycles: 16 steps, wrap back to 0.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        apply(seq_a[(j + 1) % 4], seq_b[(j + 1) % 4], 1'b0,
              4'((4 * i + j + 1) % 16), 1'b1, 1'b1, 1'b0, "up_cyc");
      end
    end
    check("up_pulses", 32'(pulses), 32'd16);
    check("up_wrap_cnt", 32'(cnt), 32'd0);
    check("up_dir", 32'(dir), 32'd1);

    // Down from 0 wraps to 15, continue down to 12.
    apply(1'b0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, "down_wrap");
    apply(1'b1, 1'b1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, "down2");
    apply(1'b1, 1'b0, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0, "down3");
    apply(1'b0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, "down4");

    // Illegal jump 00 -> 11: err set, count and dir untouched.
    apply(1'b1, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0, 1'b1, "illegal");
    pulse_clr("clr_err");

    // Count up to 7 from state 11, then clr collides with a legal up step.
    for (int k = 0; k < 7; k++) begin
      apply(seq_a[(3 + k) % 4], seq_b[(3 + k) % 4], 1'b0,
            4'(k + 1), 1'b1, 1'b1, 1'b0, "to7");
    end
    apply(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "clr_vs_step");

    // clr collides with an illegal 11 -> 00 jump: err stays clear.
    apply(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "clr_vs_illegal");

    // Up to 8, set err, then one more up step to 9.
    for (int k = 0; k < 8; k++) begin
      apply(seq_a[(k + 1) % 4], seq_b[(k + 1) % 4], 1'b0,
            4'(k + 1), 1'b1, 1'b1, 1'b0, "to8");
    end
    apply(1'b1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, "illegal2");
    a_in = 1'b0;
    b_in = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_cnt", 32'(cnt), 32'd9);
    check("pre_rst_step", 32'(step), 32'd1);

    // Asynchronous reset while clk is high: outputs clear with no edge.
    #1;
    rst = 1'b0;
    #1;
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_dir", 32'(dir), 32'd0);
    check("async_step", 32'(step), 32'd0);
    check("async_err", 32'(err), 32'd0);
    check("async_state", 32'(int'(dut.state_q)), 32'd0);

    // Release with inputs at 01: flush must not count a step.
    @(posedge clk);
    #1;
    rst = 1'b1;
    base_pulses = pulses;
    repeat (6) tick();
    check("reinit_no_step", 32'(pulses - base_pulses), 32'd0);
    check("reinit_cnt", 32'(cnt), 32'd0);
    check("reinit_err", 32'(err), 32'd0);
    m_cnt = 4'd0;
    m_err = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, "after_reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
